// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control unit: FSM encoding,
// default debounce length and time field widths.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } sw_state_e;

  localparam int DEBOUNCE_DEFAULT = 100_000;

  localparam int MSEC_W = 7;
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

endpackage

// File: rtl/btn_debounce.sv
// One button path: 2-FF synchronizer, stability counter and a registered
// rising-edge press pulse. Releases are debounced but never pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 100_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          prev_q, press_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any sample matching the accepted level restarts the stability count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) level_d = sync2_q;
      else                  cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      press_q <= level_q & ~prev_q;
      cnt_q   <= cnt_d;
    end
  end

  assign o_press = press_q;

endmodule

// File: rtl/stopwatch_cu.sv
// Stopwatch control unit: button debouncing, STOP/RUN/CLEAR sequencing and
// the optional lap-hold display freeze (enabled by defining STOPWATCH_LAP_EN).
module stopwatch_cu
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_btn_runstop,
  input  logic              i_btn_clear,
  input  logic              i_btn_lap,
  input  logic [MSEC_W-1:0] i_msec,
  input  logic [SEC_W-1:0]  i_sec,
  input  logic [MIN_W-1:0]  i_min,
  input  logic [HOUR_W-1:0] i_hour,
  output logic              o_runstop,
  output logic              o_clear,
  output logic              o_lap_hold,
  output logic [MSEC_W-1:0] o_msec,
  output logic [SEC_W-1:0]  o_sec,
  output logic [MIN_W-1:0]  o_min,
  output logic [HOUR_W-1:0] o_hour
);

  sw_state_e state_q, state_d;
  logic      rs_press, clr_press, lap_press;
  logic      lap_toggle, lap_release;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_runstop (
    .clk(clk), .rst(rst), .i_btn(i_btn_runstop), .o_press(rs_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk(clk), .rst(rst), .i_btn(i_btn_clear), .o_press(clr_press)
  );

`ifdef STOPWATCH_LAP_EN
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
    .clk(clk), .rst(rst), .i_btn(i_btn_lap), .o_press(lap_press)
  );
`else
  assign lap_press = 1'b0;
`endif

  // Priority runstop > clear > lap; a lower-priority pulse in the same clock is dropped.
  always_comb begin
    state_d     = state_q;
    lap_toggle  = 1'b0;
    lap_release = 1'b0;
    unique case (state_q)
      ST_STOP: begin
        if (rs_press)       state_d     = ST_RUN;
        else if (clr_press) state_d     = ST_CLEAR;
        else if (lap_press) lap_release = 1'b1;
      end
      ST_RUN: begin
        if (rs_press)                     state_d    = ST_STOP;
        else if (!clr_press && lap_press) lap_toggle = 1'b1;
      end
      ST_CLEAR: begin
        state_d     = ST_STOP;
        lap_release = 1'b1;
      end
      default: state_d = ST_STOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_STOP;
    else     state_q <= state_d;
  end

  assign o_runstop = (state_q == ST_RUN);
  assign o_clear   = (state_q == ST_CLEAR);

`ifdef STOPWATCH_LAP_EN
  logic              hold_q, hold_d, capture;
  logic [MSEC_W-1:0] lap_msec_q;
  logic [SEC_W-1:0]  lap_sec_q;
  logic [MIN_W-1:0]  lap_min_q;
  logic [HOUR_W-1:0] lap_hour_q;

  always_comb begin
    hold_d  = hold_q;
    capture = 1'b0;
    if (lap_release) begin
      hold_d = 1'b0;
    end else if (lap_toggle) begin
      hold_d  = ~hold_q;
      capture = ~hold_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q     <= 1'b0;
      lap_msec_q <= '0;
      lap_sec_q  <= '0;
      lap_min_q  <= '0;
      lap_hour_q <= '0;
    end else begin
      hold_q <= hold_d;
      if (capture) begin
        lap_msec_q <= i_msec;
        lap_sec_q  <= i_sec;
        lap_min_q  <= i_min;
        lap_hour_q <= i_hour;
      end
    end
  end

  assign o_lap_hold = hold_q;
  assign o_msec     = hold_q ? lap_msec_q : i_msec;
  assign o_sec      = hold_q ? lap_sec_q  : i_sec;
  assign o_min      = hold_q ? lap_min_q  : i_min;
  assign o_hour     = hold_q ? lap_hour_q : i_hour;
`else
  logic unused_lap;
  assign unused_lap = i_btn_lap ^ lap_toggle ^ lap_release;

  assign o_lap_hold = 1'b0;
  assign o_msec     = i_msec;
  assign o_sec      = i_sec;
  assign o_min      = i_min;
  assign o_hour     = i_hour;
`endif

endmodule

// File: doc/stopwatch_cu.md
# stopwatch_cu

Control unit for the stopwatch datapath. It debounces the three board buttons (run/stop, clear, lap) and sequences the datapath through STOP, RUN and CLEAR with a three-state FSM. It drives the datapath's run-enable and clear inputs. It also owns an optional lap-hold register that freezes the displayed time while the datapath keeps counting. It sits between the button pins and the datapath; its display outputs feed the FND driver.

## Interface

Parameters:
- DEBOUNCE_CYCLES, 100_000 — consecutive stable clocks (1 ms at 100 MHz) before a button level is accepted.

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  reset, synchronous, active-high
- i_btn_runstop  input  1  raw run/stop button, asynchronous to clk
- i_btn_clear  input  1  raw clear button, asynchronous
- i_btn_lap  input  1  raw lap button, asynchronous
- i_msec / i_sec / i_min / i_hour  input  7/6/6/5  live time from the datapath
- o_runstop  output  1  datapath run-enable
- o_clear  output  1  datapath clear, one-cycle pulse
- o_lap_hold  output  1  high while the display is frozen
- o_msec / o_sec / o_min / o_hour  output  7/6/6/5  time to display

## Operation

- Each button path:
  - 2-FF synchronizer.
  - Stability counter: the debounced level updates only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive clocks. Any bounce restarts the count.
  - Rising-edge detector produces a one-clock press pulse. Releases produce no pulse.
- FSM states and transitions:
  - STOP: o_runstop=0.
    - runstop press → RUN.
    - clear press → CLEAR.
    - lap press → releases lap hold.
  - RUN: o_runstop=1.
    - runstop press → STOP.
    - clear press is ignored.
    - lap press toggles lap hold. Entering hold captures i_msec..i_hour into the lap registers in the same clock.
  - CLEAR: o_clear=1 and o_runstop=0 for exactly one clock, then unconditionally → STOP. Lap hold is released. Presses arriving while in CLEAR are dropped.
- Simultaneous press pulses in one clock: priority is runstop > clear > lap; lower-priority pulses are discarded.
- Display outputs:
  - o_lap_hold=1: outputs are the lap registers.
  - o_lap_hold=0: outputs are the live i_* values, passed combinationally.
- Capture rule: lap values are sampled exactly as presented. The block performs no range checking or arithmetic on them.

## Timing

- Reset values:
  - State=STOP.
  - o_runstop=0, o_clear=0, o_lap_hold=0, lap registers=0.
  - Synchronizers, debounced levels and edge registers are all 0 (released).
- Press latency: the raw input is held high from sampling edge 0.
  - The press pulse is asserted in cycle DEBOUNCE_CYCLES+3.
  - The FSM registers update at the next edge, so o_runstop, o_clear and o_lap_hold change in cycle DEBOUNCE_CYCLES+4.
- o_clear is high for exactly one cycle per accepted clear press. A held button produces exactly one pulse.
- Reset asserted mid-operation:
  - All state returns to reset values at that edge.
  - A debounce count in progress is discarded.
  - A button held through reset release produces one press after the full debounce latency.

## Configuration

- STOPWATCH_LAP_EN defined:
  - Lap debouncer, lap registers and hold logic are present.
  - Behaviour is as described above.
- STOPWATCH_LAP_EN undefined:
  - i_btn_lap is unused and no lap debouncer is instantiated.
  - o_lap_hold is tied 0 and o_* equal i_* permanently.
  - FSM behaviour is otherwise unchanged.

## Structure

- Package stopwatch_pkg holds:
  - The FSM state encoding: STOP=2'd0, RUN=2'd1, CLEAR=2'd2.
  - The default debounce count, 100_000.
  - Time field widths: 7/6/6/5.
- Sub-module btn_debounce (synchronizer + stability counter + edge pulse, parameter DEBOUNCE_CYCLES). It is instantiated once per button: three instances with the lap path enabled, two without.
- The FSM, lap registers and display mux live in stopwatch_cu.

## Test plan

Bench uses DEBOUNCE_CYCLES=4.

- Reset then idle 20 clocks → o_runstop=0, o_clear=0, o_lap_hold=0; o_* track i_*.
- Runstop held 10 clocks → o_runstop rises exactly 8 clocks after the first high sample. A second press → o_runstop=0. A 3-clock glitch → no change.
- In STOP, clear press → o_clear=1 for exactly one clock, then state STOP. In RUN, clear press → o_clear stays 0.
- In RUN with i_sec=12 and i_msec=34, lap press → o_lap_hold=1 and o_sec/o_msec hold 12/34 while i_* advance. Second lap press → o_* follow i_*. Clear from STOP → hold released.
- Runstop and clear pulses in the same clock from STOP → RUN entered, no o_clear. Assert rst while in RUN with hold active → all outputs at reset values on the next edge.
- Build without STOPWATCH_LAP_EN, lap press in RUN → o_lap_hold=0 and o_*=i_*.
